// File: rtl/fetch_inst_queue_if.sv
// Fetch-to-decode instruction queue bundle: enqueue lanes from IFU, dequeue lanes to IDU.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_inst_queue_if #(
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 2,
    parameter int DEQ_WIDTH = 2,
    parameter int META_W    = 41
);
    logic                          flush;
    logic [ENQ_WIDTH-1:0]          enq_valid;
    logic [ENQ_WIDTH*32-1:0]       enq_pc;
    logic [ENQ_WIDTH*32-1:0]       enq_inst;
    logic [ENQ_WIDTH*META_W-1:0]   enq_meta;
    logic                          enq_ready;
    logic [DEQ_WIDTH-1:0]          deq_valid;
    logic [DEQ_WIDTH*32-1:0]       deq_pc;
    logic [DEQ_WIDTH*32-1:0]       deq_inst;
    logic [DEQ_WIDTH*META_W-1:0]   deq_meta;
    logic [DEQ_WIDTH-1:0]          deq_ready;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output flush, enq_valid, enq_pc, enq_inst, enq_meta, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_inst, deq_meta, count
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_inst, enq_meta, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_inst, deq_meta, count
    );
endinterface

// File: rtl/fetch_inst_queue.sv
// Multi-lane in-order instruction queue between fetch and decode, flushed on redirect.
// Optional same-cycle empty-queue forwarding is enabled by defining INSTQ_BYPASS_EN.
module fetch_inst_queue #(
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 2,
    parameter int DEQ_WIDTH = 2,
    parameter int META_W    = 41
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_inst_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [31:0]          pc_q   [DEPTH];
    logic [31:0]          pc_d   [DEPTH];
    logic [31:0]          inst_q [DEPTH];
    logic [31:0]          inst_d [DEPTH];
    logic [META_W-1:0]    meta_q [DEPTH];
    logic [META_W-1:0]    meta_d [DEPTH];

    logic                 enq_ready;
    logic                 enq_fire;
    logic                 bypass;
    logic                 run;
    logic [CNT_W-1:0]     enq_n, deq_n, skip;
    logic [CNT_W-1:0]     rank [ENQ_WIDTH];
    logic [DEQ_WIDTH-1:0] deq_valid;
    logic [PTR_W-1:0]     rd_ptr, slot;
    logic [31:0]          pc_r, inst_r;
    logic [META_W-1:0]    meta_r;

    // Ready looks only at the registered count, so a full queue stays closed even while draining.
    assign enq_ready   = (count_q <= CNT_W'(DEPTH - ENQ_WIDTH));
    assign q.enq_ready = enq_ready;
    assign q.deq_valid = deq_valid;
    assign q.count     = count_q;

    // rank[i] is the compacted position of lane i among the valid lanes.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            rank[i] = enq_n;
            if (q.enq_valid[i]) enq_n = enq_n + CNT_W'(1);
        end
    end

    always_comb begin
        bypass = 1'b0;
`ifdef INSTQ_BYPASS_EN
        bypass = (count_q == '0) && !q.flush;
`endif
        q.deq_pc   = '0;
        q.deq_inst = '0;
        q.deq_meta = '0;
        deq_valid  = '0;
        rd_ptr     = '0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            rd_ptr       = head_q + PTR_W'(j);
            deq_valid[j] = count_q > CNT_W'(j);
            pc_r         = pc_q[rd_ptr];
            inst_r       = inst_q[rd_ptr];
            meta_r       = meta_q[rd_ptr];
            if (bypass) begin
                deq_valid[j] = enq_n > CNT_W'(j);
                pc_r         = '0;
                inst_r       = '0;
                meta_r       = '0;
                for (int i = 0; i < ENQ_WIDTH; i++) begin
                    if (q.enq_valid[i] && rank[i] == CNT_W'(j)) begin
                        pc_r   = q.enq_pc[i*32 +: 32];
                        inst_r = q.enq_inst[i*32 +: 32];
                        meta_r = q.enq_meta[i*META_W +: META_W];
                    end
                end
            end
            // Idle lanes present zero payload rather than stale storage.
            if (deq_valid[j]) begin
                q.deq_pc[j*32 +: 32]           = pc_r;
                q.deq_inst[j*32 +: 32]         = inst_r;
                q.deq_meta[j*META_W +: META_W] = meta_r;
            end
        end

        deq_n = '0;
        run   = 1'b1;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            if (run && deq_valid[j] && q.deq_ready[j]) deq_n = deq_n + CNT_W'(1);
            else run = 1'b0;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        meta_d   = meta_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        slot     = '0;
        skip     = bypass ? deq_n : '0;
        enq_fire = enq_ready && (|q.enq_valid) && !q.flush;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                // Lanes already consumed through the bypass are not stored.
                for (int i = 0; i < ENQ_WIDTH; i++) begin
                    if (q.enq_valid[i] && rank[i] >= skip) begin
                        slot         = tail_q + PTR_W'(rank[i] - skip);
                        pc_d[slot]   = q.enq_pc[i*32 +: 32];
                        inst_d[slot] = q.enq_inst[i*32 +: 32];
                        meta_d[slot] = q.enq_meta[i*META_W +: META_W];
                    end
                end
                tail_d  = tail_q + PTR_W'(enq_n - skip);
                count_d = count_q + enq_n - deq_n;
            end else begin
                count_d = count_q - deq_n;
            end
            head_d = head_q + (bypass ? PTR_W'(0) : PTR_W'(deq_n));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
        meta_q <= meta_d;
    end

    deq_ready_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
        ((q.deq_ready + DEQ_WIDTH'(1)) & q.deq_ready) == '0);
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: driver pushes accepted pcs, negedge monitor pops on dequeue.
`timescale 1ns/1ps
module tb_fetch_inst_queue;
    localparam int DEPTH     = 8;
    localparam int ENQ_WIDTH = 2;
    localparam int DEQ_WIDTH = 2;
    localparam int META_W    = 41;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          rx_cnt = 0;
    logic [31:0] sb [$];
    bit          mon_run;
    logic [31:0] mon_exp;

    fetch_inst_queue_if #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH), .DEQ_WIDTH(DEQ_WIDTH), .META_W(META_W)) qif ();

    fetch_inst_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH), .DEQ_WIDTH(DEQ_WIDTH), .META_W(META_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [META_W-1:0] meta_of(input logic [31:0] pc);
        return {pc[9:2], pc + 32'd8, pc[2]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        qif.enq_valid = '0;
        qif.deq_ready = '0;
        qif.flush     = 1'b0;
    endtask

    task automatic drive_enq(input logic [1:0] v, input logic [31:0] pa, input logic [31:0] pb);
        qif.enq_valid = v;
        qif.enq_pc    = {pb, pa};
        qif.enq_inst  = {inst_of(pb), inst_of(pa)};
        qif.enq_meta  = {meta_of(pb), meta_of(pa)};
        if (qif.enq_ready && !qif.flush) begin
            if (v[0]) sb.push_back(pa);
            if (v[1]) sb.push_back(pb);
        end
    endtask

    task automatic drain_all(input string name);
        qif.enq_valid = '0;
        qif.deq_ready = 2'b11;
        for (int c = 0; c < 20 && qif.count != '0; c++) cyc();
        qif.deq_ready = '0;
        check(name, 64'(qif.count), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && !qif.flush) begin
            mon_run = 1'b1;
            for (int j = 0; j < DEQ_WIDTH; j++) begin
                if (mon_run && qif.deq_valid[j] && qif.deq_ready[j]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL deq_unexpected lane=%0d actual_pc=0x%0h required=no_entry", j, qif.deq_pc[j*32 +: 32]);
                    end else begin
                        mon_exp = sb.pop_front();
                        check("deq_pc",   64'(qif.deq_pc[j*32 +: 32]), 64'(mon_exp));
                        check("deq_inst", 64'(qif.deq_inst[j*32 +: 32]), 64'(inst_of(mon_exp)));
                        check("deq_meta", 64'(qif.deq_meta[j*META_W +: META_W]), 64'(meta_of(mon_exp)));
                        rx_cnt++;
                    end
                end else begin
                    mon_run = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [1:0]  v;
        logic [31:0] pa, pb;
        int          sent, rx_start;

        qif.enq_pc   = '0;
        qif.enq_inst = '0;
        qif.enq_meta = '0;
        idle();

        // Reset and idle
        #12;
        check("rst_count", 64'(qif.count), 64'd0);
        check("rst_deq_valid", 64'(qif.deq_valid), 64'd0);
        check("rst_enq_ready", 64'(qif.enq_ready), 64'd1);
        check("rst_deq_pc", 64'(qif.deq_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();
        check("idle_count", 64'(qif.count), 64'd0);
        check("idle_deq_valid", 64'(qif.deq_valid), 64'd0);
        check("idle_enq_ready", 64'(qif.enq_ready), 64'd1);

        // Two-lane enqueue, visible next cycle
        drive_enq(2'b11, 32'h8000_0000, 32'h8000_0004);
        cyc();
        idle();
        check("enq2_count", 64'(qif.count), 64'd2);
        check("enq2_deq_valid", 64'(qif.deq_valid), 64'd3);
        check("enq2_pc0", 64'(qif.deq_pc[31:0]), 64'h8000_0000);
        check("enq2_pc1", 64'(qif.deq_pc[63:32]), 64'h8000_0004);
        qif.deq_ready = 2'b11;
        cyc();
        idle();
        check("enq2_drained", 64'(qif.count), 64'd0);

        // Compaction of a lone lane 1
        drive_enq(2'b10, 32'h0, 32'h1004);
        cyc();
        idle();
        check("cmp_count", 64'(qif.count), 64'd1);
        check("cmp_deq_valid", 64'(qif.deq_valid), 64'd1);
        check("cmp_pc0", 64'(qif.deq_pc[31:0]), 64'h1004);
        qif.deq_ready = 2'b01;
        cyc();
        idle();
        check("cmp_drained", 64'(qif.count), 64'd0);

        // Fill to 7, then dequeue two while a blocked enqueue is offered
        for (int k = 0; k < 3; k++) begin
            drive_enq(2'b11, 32'h3000 + 32'(8 * k), 32'h3004 + 32'(8 * k));
            cyc();
        end
        idle();
        check("fill6_enq_ready", 64'(qif.enq_ready), 64'd1);
        drive_enq(2'b01, 32'h3018, 32'h0);
        cyc();
        idle();
        check("fill7_count", 64'(qif.count), 64'd7);
        check("fill7_enq_ready", 64'(qif.enq_ready), 64'd0);
        qif.deq_ready = 2'b11;
        drive_enq(2'b11, 32'h3f00, 32'h3f04);
        cyc();
        idle();
        check("fill_deq_count", 64'(qif.count), 64'd5);
        check("fill_deq_enq_ready", 64'(qif.enq_ready), 64'd1);
        drain_all("fill_drained");

        // Streaming with random stalls on both sides
        sent = 0;
        rx_start = rx_cnt;
        for (int c = 0; c < 600 && sent < 40; c++) begin
            v = 2'($urandom_range(0, 3));
            if (sent == 39 && v == 2'b11) v = 2'b01;
            pa = 32'h4000 + 32'(4 * sent);
            pb = v[0] ? pa + 32'd4 : pa;
            if (qif.enq_ready) sent += int'(v[0]) + int'(v[1]);
            drive_enq(v, pa, pb);
            case ($urandom_range(0, 2))
                0:       qif.deq_ready = 2'b00;
                1:       qif.deq_ready = 2'b01;
                default: qif.deq_ready = 2'b11;
            endcase
            cyc();
        end
        idle();
        drain_all("stream_drained");
        check("stream_sent", 64'(sent), 64'd40);
        check("stream_rx", 64'(rx_cnt - rx_start), 64'd40);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset between clock edges
        drive_enq(2'b11, 32'h6000, 32'h6004);
        cyc();
        idle();
        check("arst_pre_count", 64'(qif.count), 64'd2);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_count", 64'(qif.count), 64'd0);
        check("arst_deq_valid", 64'(qif.deq_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Flush wins over same-cycle enqueue and dequeue
        drive_enq(2'b11, 32'h7000, 32'h7004);
        cyc();
        drive_enq(2'b11, 32'h7008, 32'h700c);
        cyc();
        idle();
        check("flush_pre_count", 64'(qif.count), 64'd4);
        qif.flush = 1'b1;
        sb.delete();
        qif.deq_ready = 2'b11;
        drive_enq(2'b11, 32'h7010, 32'h7014);
        cyc();
        idle();
        check("flush_count", 64'(qif.count), 64'd0);
        check("flush_deq_valid", 64'(qif.deq_valid), 64'd0);
        check("flush_enq_ready", 64'(qif.enq_ready), 64'd1);
        drive_enq(2'b01, 32'h5000, 32'h0);
        cyc();
        idle();
        check("post_flush_count", 64'(qif.count), 64'd1);
        check("post_flush_pc0", 64'(qif.deq_pc[31:0]), 64'h5000);
        drain_all("post_flush_drained");

`ifdef INSTQ_BYPASS_EN
        // Same-cycle forwarding into an empty queue
        drive_enq(2'b01, 32'h2000, 32'h0);
        qif.deq_ready = 2'b01;
        #1;
        check("byp_deq_valid0", 64'(qif.deq_valid[0]), 64'd1);
        check("byp_pc0", 64'(qif.deq_pc[31:0]), 64'h2000);
        cyc();
        idle();
        check("byp_count", 64'(qif.count), 64'd0);
`endif

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
